// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch queue: fetches sequentially from a combinational memory
// into a circular buffer of {pc, instr} entries that are drained by decode.
module fetch_queue_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic [31:0]             imem_addr_o,
  input  logic [31:0]             imem_instr_i,
  input  logic                    redirect_i,
  input  logic [31:0]             redirect_pc_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [31:0]             instr_o,
  output logic [31:0]             pc_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  // DEPTH is a power of two, so "full" is just the top count bit.
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          valid;
  logic          deq;
  logic          enq;

  always_comb begin
    valid = (count != '0);
    deq   = valid & ready_i & ~redirect_i;
    enq   = ~redirect_i & ((count != FULL) | deq);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= redirect_pc_i & ~32'h3;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enq) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr_i;
    end
  end

  assign imem_addr_o = fetch_pc;
  assign valid_o     = valid;
  assign count_o     = count;
  assign instr_o     = valid ? instr_mem[rd_ptr] : '0;
  assign pc_o        = valid ? pc_mem[rd_ptr]    : '0;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: directed vector table, a bounded fill sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_queue_ctrl;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [$clog2(DEPTH):0] count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_queue_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .count_o       (count_o)
  );

  // Memory contents: word k holds (k+1)*0x11, so addresses 0,4,8 give 0x11,0x22,0x33.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({2'b00, a[31:2]} + 32'd1) * 32'h11;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned cnt;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic redir, input logic [31:0] rpc,
                              input logic rdy, input logic v, input logic [31:0] pc,
                              input logic [31:0] instr, input int unsigned cnt,
                              input logic [31:0] addr);
    vec_t t;
    t.rst = rst; t.redir = redir; t.rpc = rpc; t.rdy = rdy;
    t.v = v; t.pc = pc; t.instr = instr; t.cnt = cnt; t.addr = addr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic d, input logic [31:0] p, input logic y);
    rst_i = r; redirect_i = d; redirect_pc_i = p; ready_i = y;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of {pc, instr} entries plus the next fetch address.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      mq[$];
  logic [31:0] mpc;

  task automatic model_step(input logic r, input logic d, input logic [31:0] p, input logic y);
    bit took, put;
    entry_t e;
    if (r) begin
      mq.delete();
      mpc = RESET_PC;
    end else if (d) begin
      mq.delete();
      mpc = {p[31:2], 2'b00};
    end else begin
      took = (mq.size() > 0) && y;
      put  = (mq.size() < DEPTH) || took;
      if (took) void'(mq.pop_front());
      if (put) begin
        e.pc = mpc; e.instr = mem_word(mpc);
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  initial begin
    int n;
    logic r, d, y;
    logic [31:0] p;

    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;

    // Sequential streaming from reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 32'h0,  0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h11, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h22, 1, 32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h8, 32'h33, 1, 32'hC));
    // Saturation with decode stalled, then one dequeue while full
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 32'h0,  0, 32'h0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h11, (i < 4) ? i : 4,
                       (i < 4) ? 32'(4 * i) : 32'h10));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h22, 4, 32'h14));
    // Redirect with count=3 and ready high: redirect wins, target aligned
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0, 32'h0,  0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h11, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h11, 2, 32'h8));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h11, 3, 32'hC));
    tbl.push_back(mk(0, 1, 32'h103, 1, 0, 32'h0, 32'h0, 0, 32'h100));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 32'h451, 1, 32'h104));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 32'h451, 2, 32'h108));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 32'h451, 3, 32'h10C));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h100, 32'h451, 4, 32'h110));
    // Reset beats a simultaneous redirect
    tbl.push_back(mk(1, 1, 32'h200, 1, 0, 32'h0, 32'h0, 0, RESET_PC));
    // Address wrap-around after redirect to the top word
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h4000_0000, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h4000_0000, 2, 32'h4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h4000_0000, 3, 32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h11, 3, 32'hC));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h22, 3, 32'h10));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(tbl[i].v));
      chk($sformatf("vec%0d.pc", i), pc_o, tbl[i].pc);
      chk($sformatf("vec%0d.instr", i), instr_o, tbl[i].instr);
      chk($sformatf("vec%0d.count", i), 32'(count_o), tbl[i].cnt);
      chk($sformatf("vec%0d.addr", i), imem_addr_o, tbl[i].addr);
    end

    // Bounded fill from empty: must reach full in exactly DEPTH edges
    apply(1, 0, 0, 0);
    n = 0;
    while (count_o != DEPTH && n < 20) begin
      apply(0, 0, 0, 0);
      n++;
    end
    chk("fill_cycles", 32'(n), 32'(DEPTH));
    chk("fill_addr", imem_addr_o, RESET_PC + 32'(4 * DEPTH));
    apply(0, 0, 0, 0);
    chk("full_hold_addr", imem_addr_o, RESET_PC + 32'(4 * DEPTH));

    // Randomized traffic against the reference model
    apply(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(99) < 2);
      d = ($urandom_range(99) < 8);
      y = ($urandom_range(99) < 60);
      p = $urandom();
      if ($urandom_range(3) == 0) p = 32'hFFFF_FFF0 | (p & 32'hF);
      apply(r, d, p, y);
      model_step(r, d, p, y);
      chk("rnd.valid", 32'(valid_o), 32'(mq.size() != 0));
      chk("rnd.count", 32'(count_o), 32'(mq.size()));
      chk("rnd.addr", imem_addr_o, mpc);
      chk("rnd.pc", pc_o, (mq.size() != 0) ? mq[0].pc : 32'h0);
      chk("rnd.instr", instr_o, (mq.size() != 0) ? mq[0].instr : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
